// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared types and helpers for the traffic lamp monitor.
//   lane_state_e : decoded state of one lane's {red, yellow, green} drive
//   mon_state_e  : monitor FSM states
//   FC_*         : fault codes (0 = none, 1..5 in priority order)
//   decode_lane  : {X,V,D} lamp vector -> lane_state_e
//   sat_inc8     : 8-bit increment that sticks at 255
// -----------------------------------------------------------------------------
package traffic_pkg;

   typedef enum logic [2:0] {
      LANE_DARK  = 3'd0,
      LANE_RED   = 3'd1,
      LANE_YEL   = 3'd2,
      LANE_GRN   = 3'd3,
      LANE_MULTI = 3'd4
   } lane_state_e;

   typedef enum logic [1:0] {
      ST_MONITOR  = 2'd0,
      ST_FAULT    = 2'd1,
      ST_CLEARING = 2'd2
   } mon_state_e;

   localparam logic [2:0] FC_NONE         = 3'd0;
   localparam logic [2:0] FC_ILLEGAL      = 3'd1;
   localparam logic [2:0] FC_CONFLICT     = 3'd2;
   localparam logic [2:0] FC_SKIP_YELLOW  = 3'd3;
   localparam logic [2:0] FC_SHORT_YELLOW = 3'd4;
   localparam logic [2:0] FC_DARK_TIMEOUT = 3'd5;

   // Exactly one lamp lit is a proper aspect; nothing lit is DARK; anything else is MULTI.
   function automatic lane_state_e decode_lane(input logic [2:0] xvd);
      lane_state_e st;
      case (xvd)
         3'b100:  st = LANE_RED;
         3'b010:  st = LANE_YEL;
         3'b001:  st = LANE_GRN;
         3'b000:  st = LANE_DARK;
         default: st = LANE_MULTI;
      endcase
      return st;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'hFF) begin
         r = 8'hFF;
      end else begin
         r = v + 8'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/lamp_lane_check.sv
// -----------------------------------------------------------------------------
// lamp_lane_check
// Per-lane checker: decodes the registered lamp vector, tracks the previous
// sample and the length of the current yellow run, and flags lane-local rule
// violations.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   lamp_i[2:0] : registered {X,V,D} drive of this lane
//   smp_vld_i   : lamp_i holds a real sample (not the reset value)
//   state_o     : decoded lane state of the current sample
//   multi_o     : more than one lamp lit
//   skip_o      : GRN directly followed by RED
//   short_o     : YEL left after fewer than YELLOW_MIN samples
// -----------------------------------------------------------------------------
module lamp_lane_check
   import traffic_pkg::*;
#(
   parameter int unsigned YELLOW_MIN = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  lamp_i,
   input  logic        smp_vld_i,
   output lane_state_e state_o,
   output logic        multi_o,
   output logic        skip_o,
   output logic        short_o
);

   localparam logic [7:0] YMIN8 = YELLOW_MIN[7:0];

   lane_state_e cur_s;
   lane_state_e prev_q, prev_d;
   logic        hist_vld_q, hist_vld_d;
   logic [7:0]  yel_cnt_q, yel_cnt_d;

   assign state_o = cur_s;

   // Decode, next-state of the history registers, and the lane flags.
   always_comb begin
      cur_s      = decode_lane(lamp_i);
      prev_d     = cur_s;
      // prev_q only describes a real sample once two samples have been taken.
      hist_vld_d = hist_vld_q | smp_vld_i;
      // The run length restarts from zero on entry to YEL, so the first YEL
      // sample counts as one; yel_cnt_q is the run ending at the previous sample.
      if (cur_s == LANE_YEL) begin
         yel_cnt_d = sat_inc8(yel_cnt_q);
      end else begin
         yel_cnt_d = 8'd0;
      end
      multi_o = (cur_s == LANE_MULTI);
      if (hist_vld_q) begin
         skip_o  = (prev_q == LANE_GRN) && (cur_s == LANE_RED);
         short_o = (prev_q == LANE_YEL) && (cur_s != LANE_YEL) && (yel_cnt_q < YMIN8);
      end else begin
         skip_o  = 1'b0;
         short_o = 1'b0;
      end
   end

   // Lane history registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q     <= LANE_DARK;
         hist_vld_q <= 1'b0;
         yel_cnt_q  <= 8'd0;
      end else begin
         prev_q     <= prev_d;
         hist_vld_q <= hist_vld_d;
         yel_cnt_q  <= yel_cnt_d;
      end
   end

endmodule

// File: rtl/lamp_monitor.sv
// -----------------------------------------------------------------------------
// lamp_monitor
// Safety monitor for a two-lane traffic lamp driver. Samples the six lamp
// drives once, checks lane and lane-pair rules, latches the first fault code
// and requests fail-safe flashing until the fault is cleared.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   Xa, Va, Da      : lane A red / yellow / green drive
//   Xb, Vb, Db      : lane B red / yellow / green drive
//   fault_clr       : single-cycle request to clear a latched fault
//   fault           : latched fault indication
//   fault_code[2:0] : first fault captured (0 = none)
//   fault_cnt[7:0]  : saturating count of faults (only with FAULT_CNT_EN)
//   safe_flash      : flashing-yellow request, high in FAULT and CLEARING
// Build option: define FAULT_CNT_EN to add the fault_cnt port and counter.
// -----------------------------------------------------------------------------
module lamp_monitor
   import traffic_pkg::*;
#(
   parameter int unsigned YELLOW_MIN = 4,
   parameter int unsigned DARK_MAX   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       Xa,
   input  logic       Va,
   input  logic       Da,
   input  logic       Xb,
   input  logic       Vb,
   input  logic       Db,
   input  logic       fault_clr,
   output logic       fault,
   output logic [2:0] fault_code,
`ifdef FAULT_CNT_EN
   output logic [7:0] fault_cnt,
`endif
   output logic       safe_flash
);

   localparam logic [7:0] DMAX8 = DARK_MAX[7:0];

   logic [2:0]  lamp_a_q, lamp_b_q;
   logic        smp_vld_q;
   lane_state_e st_a_s, st_b_s;
   logic        multi_a_s, skip_a_s, short_a_s;
   logic        multi_b_s, skip_b_s, short_b_s;
   logic [7:0]  dark_cnt_q, dark_cnt_d;
   logic        go_a_s, go_b_s, dark_tmo_s, safe_lamps_s;
   logic [2:0]  viol_code_s;

   mon_state_e  state_q;
   logic        fault_q;
   logic [2:0]  code_q;
   logic        flash_q;
   logic        clr_cnt_q;

   // Single registration stage for the lamp drives; all checks use this copy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lamp_a_q  <= 3'b000;
         lamp_b_q  <= 3'b000;
         smp_vld_q <= 1'b0;
      end else begin
         lamp_a_q  <= {Xa, Va, Da};
         lamp_b_q  <= {Xb, Vb, Db};
         smp_vld_q <= 1'b1;
      end
   end

   lamp_lane_check #(.YELLOW_MIN(YELLOW_MIN)) u_lane_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .lamp_i    (lamp_a_q),
      .smp_vld_i (smp_vld_q),
      .state_o   (st_a_s),
      .multi_o   (multi_a_s),
      .skip_o    (skip_a_s),
      .short_o   (short_a_s)
   );

   lamp_lane_check #(.YELLOW_MIN(YELLOW_MIN)) u_lane_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .lamp_i    (lamp_b_q),
      .smp_vld_i (smp_vld_q),
      .state_o   (st_b_s),
      .multi_o   (multi_b_s),
      .skip_o    (skip_b_s),
      .short_o   (short_b_s)
   );

   // Lane-pair checks and priority encoding of the violation code.
   always_comb begin
      go_a_s = (st_a_s == LANE_GRN) || (st_a_s == LANE_YEL);
      go_b_s = (st_b_s == LANE_GRN) || (st_b_s == LANE_YEL);
      // The reset value of the lamp registers is not a sample, so it never
      // starts an all-dark run.
      if (smp_vld_q && (st_a_s == LANE_DARK) && (st_b_s == LANE_DARK)) begin
         dark_cnt_d = sat_inc8(dark_cnt_q);
      end else begin
         dark_cnt_d = 8'd0;
      end
      dark_tmo_s   = (dark_cnt_d > DMAX8);
      safe_lamps_s = ((st_a_s == LANE_RED) || (st_a_s == LANE_DARK)) &&
                     ((st_b_s == LANE_RED) || (st_b_s == LANE_DARK));
      if (multi_a_s || multi_b_s) begin
         viol_code_s = FC_ILLEGAL;
      end else if (go_a_s && go_b_s) begin
         viol_code_s = FC_CONFLICT;
      end else if (skip_a_s || skip_b_s) begin
         viol_code_s = FC_SKIP_YELLOW;
      end else if (short_a_s || short_b_s) begin
         viol_code_s = FC_SHORT_YELLOW;
      end else if (dark_tmo_s) begin
         viol_code_s = FC_DARK_TIMEOUT;
      end else begin
         viol_code_s = FC_NONE;
      end
   end

   // All-dark run counter; runs in every FSM state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dark_cnt_q <= 8'd0;
      end else begin
         dark_cnt_q <= dark_cnt_d;
      end
   end

   // Monitor FSM with registered fault, fault_code and safe_flash.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_MONITOR;
         fault_q   <= 1'b0;
         code_q    <= FC_NONE;
         flash_q   <= 1'b0;
         clr_cnt_q <= 1'b0;
      end else begin
         case (state_q)
            ST_MONITOR: begin
               if (viol_code_s != FC_NONE) begin
                  state_q <= ST_FAULT;
                  fault_q <= 1'b1;
                  code_q  <= viol_code_s;
                  flash_q <= 1'b1;
               end else begin
                  state_q <= ST_MONITOR;
                  fault_q <= 1'b0;
                  code_q  <= FC_NONE;
                  flash_q <= 1'b0;
               end
               clr_cnt_q <= 1'b0;
            end
            ST_FAULT: begin
               // Later violations are ignored here so the first code is kept.
               if (fault_clr) begin
                  state_q <= ST_CLEARING;
               end else begin
                  state_q <= ST_FAULT;
               end
               clr_cnt_q <= 1'b0;
            end
            ST_CLEARING: begin
               if (viol_code_s != FC_NONE) begin
                  state_q   <= ST_FAULT;
                  clr_cnt_q <= 1'b0;
               end else if (safe_lamps_s) begin
                  if (clr_cnt_q) begin
                     state_q   <= ST_MONITOR;
                     fault_q   <= 1'b0;
                     code_q    <= FC_NONE;
                     flash_q   <= 1'b0;
                     clr_cnt_q <= 1'b0;
                  end else begin
                     state_q   <= ST_CLEARING;
                     clr_cnt_q <= 1'b1;
                  end
               end else begin
                  state_q   <= ST_CLEARING;
                  clr_cnt_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= ST_MONITOR;
               fault_q   <= 1'b0;
               code_q    <= FC_NONE;
               flash_q   <= 1'b0;
               clr_cnt_q <= 1'b0;
            end
         endcase
      end
   end

   assign fault      = fault_q;
   assign fault_code = code_q;
   assign safe_flash = flash_q;

`ifdef FAULT_CNT_EN
   logic [7:0] fault_cnt_q;

   // Saturating tally of MONITOR -> FAULT entries; cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_cnt_q <= 8'd0;
      end else if ((state_q == ST_MONITOR) && (viol_code_s != FC_NONE)) begin
         fault_cnt_q <= sat_inc8(fault_cnt_q);
      end else begin
         fault_cnt_q <= fault_cnt_q;
      end
   end

   assign fault_cnt = fault_cnt_q;
`endif

endmodule
